// File: rtl/dut_pkg.sv
// Shared definitions for the division BIST: syndrome codes, FSM states and the
// constant vector table.
package dut_pkg;

    localparam logic [7:0] SYN_RESET    = 8'h00;
    localparam logic [7:0] SYN_RUN      = 8'hFF;
    localparam logic [7:0] SYN_PASS     = 8'h01;
    localparam logic [7:0] SYN_MISMATCH = 8'h02;
    localparam logic [7:0] SYN_DIVERR   = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCheck,
        StPass,
        StFail
    } state_e;

    typedef struct packed {
        logic [31:0] nn;
        logic [31:0] dd;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    // Vector 6 (divide by zero) only runs when the divide-by-zero test is enabled.
    function automatic vec_t get_vec(input logic [2:0] idx);
        vec_t v;
        unique case (idx)
            3'd0:    v = {32'd100,        32'd7,    32'd14,         32'd2};
            3'd1:    v = {32'hFFFF_FFFF,  32'd1,    32'hFFFF_FFFF,  32'd0};
            3'd2:    v = {32'd12345,      32'd123,  32'd100,        32'd45};
            3'd3:    v = {32'd5,          32'd9,    32'd0,          32'd5};
            3'd4:    v = {32'd1000000,    32'd1000, 32'd1000,       32'd0};
            3'd5:    v = {32'h8000_0000,  32'd3,    32'h2AAA_AAAA,  32'd2};
            3'd6:    v = {32'd7,          32'd0,    32'd0,          32'd0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/kiwi_divider.sv
// Restoring shift-subtract unsigned 32-bit divider: 32 busy cycles after req,
// then a one-cycle rdy pulse with quotient, remainder and divide-by-zero flag.
module kiwi_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] NN,
    input  logic [31:0] DD,
    output logic        rdy,
    output logic [31:0] RR,
    output logic [31:0] REM,
    output logic        err
);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] div_q;
    logic        rdy_q;
    logic        err_q;
    logic [32:0] shifted;

    always_comb begin
        shifted = {rem_q, quo_q[31]};
        quo_d   = {quo_q[30:0], 1'b0};
        rem_d   = shifted[31:0];
        if (shifted >= {1'b0, div_q}) begin
            // Partial remainder is below the divisor afterwards, so 32 bits suffice.
            rem_d = shifted[31:0] - div_q;
            quo_d = {quo_q[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (!busy_q) begin
                if (req) begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
                    quo_q  <= NN;
                    rem_q  <= '0;
                    div_q  <= DD;
                    err_q  <= 1'b0;
                end
            end else begin
                quo_q <= quo_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b1;
                    err_q  <= (div_q == '0);
                end
            end
        end
    end

    assign rdy = rdy_q;
    assign RR  = quo_q;
    assign REM = rem_q;
    assign err = err_q;

endmodule

// File: rtl/dut.sv
// Division BIST top: walks the vector table through the divider, checks each
// result and reports status/verdict on the abend syndrome.
module dut
    import dut_pkg::*;
#(
    parameter bit INJECT_FAULT  = 1'b0,
    parameter bit DIV_ZERO_TEST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] hpr_abend_syndrome
);

    localparam logic [2:0] LastIdx = DIV_ZERO_TEST ? 3'd6 : 3'd5;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  syn_q, syn_d;
    vec_t        cur;
    logic [31:0] exp_q;
    logic        div_req;
    logic        div_rdy;
    logic        div_err;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign cur   = get_vec(idx_q);
    assign exp_q = (INJECT_FAULT && idx_q == 3'd2) ? (cur.q ^ 32'd1) : cur.q;

    kiwi_divider u_div (
        .clk   (clk),
        .reset (reset),
        .req   (div_req),
        .NN    (cur.nn),
        .DD    (cur.dd),
        .rdy   (div_rdy),
        .RR    (div_quo),
        .REM   (div_rem),
        .err   (div_err)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        syn_d   = syn_q;
        div_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StIssue;
                syn_d   = SYN_RUN;
            end
            StIssue: begin
                div_req = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (div_rdy) state_d = StCheck;
            end
            StCheck: begin
                // Divider holds its results after rdy, so they are still valid here.
                if (div_err) begin
                    state_d = StFail;
                    syn_d   = SYN_DIVERR;
                end else if (div_quo != exp_q || div_rem != cur.r) begin
                    state_d = StFail;
                    syn_d   = SYN_MISMATCH;
                end else if (idx_q != LastIdx) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StIssue;
                end else begin
                    state_d = StPass;
                    syn_d   = SYN_PASS;
                end
            end
            StPass, StFail: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            syn_q   <= SYN_RESET;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            syn_q   <= syn_d;
        end
    end

    assign hpr_abend_syndrome = syn_q;

endmodule

// File: tb/tb_dut.sv
// Scoreboard bench: three BIST configurations plus a standalone divider; stimulus
// queues expected syndrome changes / divider results, monitors pop and compare.
module tb_dut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        div_rst_n;
    logic [7:0]  syn [3];

    dut u_def (
        .clk                (clk),
        .reset              (rst_n),
        .hpr_abend_syndrome (syn[0])
    );

    dut #(.INJECT_FAULT(1'b1)) u_fault (
        .clk                (clk),
        .reset              (rst_n),
        .hpr_abend_syndrome (syn[1])
    );

    dut #(.DIV_ZERO_TEST(1'b1)) u_divz (
        .clk                (clk),
        .reset              (rst_n),
        .hpr_abend_syndrome (syn[2])
    );

    logic        d_req;
    logic [31:0] d_nn, d_dd, d_q, d_r;
    logic        d_rdy, d_err;

    kiwi_divider u_div (
        .clk   (clk),
        .reset (div_rst_n),
        .req   (d_req),
        .NN    (d_nn),
        .DD    (d_dd),
        .rdy   (d_rdy),
        .RR    (d_q),
        .REM   (d_r),
        .err   (d_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc;
    int tick = 0;
    int fault_reqs;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } syn_exp_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          issue;
    } div_exp_t;

    syn_exp_t   sq [3][$];
    div_exp_t   dq [$];
    logic [7:0] prev [3];
    syn_exp_t   se;
    div_exp_t   de;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) tick <= tick + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_reqs <= 0;
        else if (u_fault.div_req) fault_reqs <= fault_reqs + 1;
    end

    // Monitor: every syndrome change and every divider rdy must match the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (syn[i] !== prev[i]) begin
                if (sq[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL syn%0d_unexpected: got %0h at cycle %0d, expected no change",
                             i, syn[i], cyc);
                end else begin
                    se = sq[i].pop_front();
                    check($sformatf("syn%0d_value", i), 32'(syn[i]), 32'(se.val));
                    if (se.cyc >= 0) check($sformatf("syn%0d_cycle", i), cyc, se.cyc);
                end
                prev[i] = syn[i];
            end
        end
        if (d_rdy === 1'b1) begin
            if (dq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL div_unexpected_rdy: got rdy at tick %0d, expected none", tick);
            end else begin
                de = dq.pop_front();
                check("div_latency", tick - de.issue, 33);
                check("div_err", 32'(d_err), 32'(de.err));
                if (!de.err) begin
                    check("div_quotient", d_q, de.q);
                    check("div_remainder", d_r, de.r);
                end
            end
        end
    end

    task automatic div_pulse(input logic [31:0] nn, input logic [31:0] dd, input bit push,
                             input logic [31:0] q, input logic [31:0] r, input logic err);
        div_exp_t e;
        @(negedge clk);
        #1;
        if (push) begin
            e.q = q; e.r = r; e.err = err; e.issue = tick;
            dq.push_back(e);
        end
        d_nn  = nn;
        d_dd  = dd;
        d_req = 1'b1;
        @(negedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic push_syn(input int i, input logic [7:0] val, input int c);
        syn_exp_t e;
        e.val = val;
        e.cyc = c;
        sq[i].push_back(e);
    endtask

    task automatic push_run(input bit with_clear);
        for (int i = 0; i < 3; i++) begin
            if (with_clear) push_syn(i, 8'h00, -1);
            push_syn(i, 8'hFF, 1);
        end
        push_syn(0, 8'h01, 211);
        push_syn(1, 8'h02, 106);
        push_syn(2, 8'h03, 246);
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_syn%0d", tag, i), 32'(syn[i]), 32'h00);
    endtask

    // Standalone divider: valid divide, a req ignored while busy, then divide by zero.
    initial begin
        d_req = 1'b0;
        d_nn  = '0;
        d_dd  = '0;
        wait (div_rst_n === 1'b1);
        repeat (3) @(negedge clk);
        div_pulse(32'h8000_0000, 32'd3, 1'b1, 32'h2AAA_AAAA, 32'd2, 1'b0);
        repeat (10) @(negedge clk);
        div_pulse(32'd7, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (30) @(negedge clk);
        div_pulse(32'd7, 32'd0, 1'b1, 32'd0, 32'd0, 1'b1);
        div_pulse(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    end

    initial begin
        for (int i = 0; i < 3; i++) prev[i] = 8'h00;
        rst_n     = 1'b0;
        div_rst_n = 1'b0;
        #1;
        check_cleared("reset_initial");
        for (int i = 0; i < 3; i++) push_syn(i, 8'hFF, 1);
        repeat (3) @(negedge clk);
        #1;
        rst_n     = 1'b1;
        div_rst_n = 1'b1;

        // Abort mid-run; the clear must be visible before any clock edge.
        while (cyc < 50) @(negedge clk);
        #2;
        push_run(1'b1);
        rst_n = 1'b0;
        #1;
        check_cleared("reset_midrun");
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        while (cyc < 350) @(negedge clk);
        #1;
        check("pass_held", 32'(syn[0]), 32'h01);
        check("mismatch_held", 32'(syn[1]), 32'h02);
        check("diverr_held", 32'(syn[2]), 32'h03);
        check("fault_vectors_issued", fault_reqs, 3);

        push_run(1'b1);
        rst_n = 1'b0;
        #1;
        check_cleared("reset_after_verdict");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        while (cyc < 260) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("syn%0d_pending_events", i), sq[i].size(), 0);
        check("div_pending_results", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
